// File: rtl/quiz_pkg.sv
// Shared quiz definitions: state encoding, question id and answer widths.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package quiz_pkg;

  localparam int NUM_QUESTIONS = 10;
  localparam int Q_ID_W        = 4;
  localparam int ANS_W         = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQUEST = 3'd1;
  localparam logic [2:0] ST_WAIT_Q  = 3'd2;
  localparam logic [2:0] ST_ANSWER  = 3'd3;
  localparam logic [2:0] ST_RESULT  = 3'd4;
  localparam logic [2:0] ST_OVER    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_REQUEST = ST_REQUEST,
    S_WAIT_Q  = ST_WAIT_Q,
    S_ANSWER  = ST_ANSWER,
    S_RESULT  = ST_RESULT,
    S_OVER    = ST_OVER
  } state_t;

endpackage

// File: rtl/quiz_round_controller_if.sv
// Question selector handshake: one-cycle request out, id/answer back with a ready strobe.
// Latency: none (wiring only).
// Backpressure: none; the selector answers whenever it likes and the controller re-requests on timeout.
interface quiz_round_controller_if;
  import quiz_pkg::*;

  logic              question_enable;
  logic              question_ready;
  logic [Q_ID_W-1:0] selected_q_id;
  logic [ANS_W-1:0]  correct_ans;

  modport master (
    output question_enable,
    input  question_ready,
    input  selected_q_id,
    input  correct_ans
  );

  modport slave (
    input  question_enable,
    output question_ready,
    output selected_q_id,
    output correct_ans
  );

endinterface

// File: rtl/quiz_round_controller_round_timer.sv
// Per-question countdown: load a value, decrement on each unfrozen tick, pulse expire on the tick reaching 0.
// Latency: time_left updates one cycle after load/tick; expire is combinational in the final-tick cycle.
// Backpressure: freeze holds the count; load overrides tick.
module round_timer #(
  parameter int TIME_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  input  logic              tick,
  input  logic              freeze,
  output logic [TIME_W-1:0] time_left,
  output logic              expire
);

  assign expire = tick && !freeze && !load && (time_left == TIME_W'(1));

  // countdown register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      time_left <= '0;
    end else if (load) begin
      time_left <= load_val;
    end else if (tick && !freeze && (time_left != '0)) begin
      time_left <= time_left - 1'b1;
    end
  end

endmodule

// File: rtl/quiz_round_controller.sv
// Quiz round sequencer: requests questions, rejects repeats, times and judges answers, keeps score/lives/rounds.
// Latency: verdict pulses and counter updates appear one cycle after the answer or final tick.
// Backpressure: re-requests after a 16-cycle selector silence; TIME_BONUS_EN adds time_left to a correct score.
module quiz_round_controller
  import quiz_pkg::*;
#(
  parameter int ROUND_TIME  = 10,
  parameter int NUM_ROUNDS  = 8,
  parameter int START_LIVES = 3,
  parameter int RESULT_HOLD = 2,
  parameter int MAX_RETRY   = 3,
  parameter int TIME_W      = 4
) (
  input  logic                    clk_100mhz,
  input  logic                    reset_n,
  input  logic                    game_tick,
  input  logic                    start,
  input  logic                    answer_valid,
  input  logic [ANS_W-1:0]        answer_value,
  quiz_round_controller_if.master selector,
  output logic [Q_ID_W-1:0]       cur_q_id,
  output logic [TIME_W-1:0]       time_left,
  output logic [7:0]              score,
  output logic [1:0]              lives,
  output logic [3:0]              round_num,
  output logic                    result_correct,
  output logic                    result_wrong,
  output logic                    game_over,
  output logic [2:0]              state_out
);

  localparam logic [NUM_QUESTIONS-1:0] MASK_FULL = '1;

  state_t                   state, state_nxt;
  logic [NUM_QUESTIONS-1:0] used_mask;
  logic [3:0]               retry;
  logic [3:0]               cnt;
  logic [ANS_W-1:0]         cur_ans;
  logic                     id_in_range, id_bad;
  logic                     accept, reject, game_start;
  logic                     verdict_ok, verdict_bad;
  logic                     timer_load, timer_freeze, expire;
  logic [TIME_W-1:0]        timer_val;
  logic [8:0]               score_sum;

  assign id_in_range  = (selector.selected_q_id < Q_ID_W'(NUM_QUESTIONS));
  assign id_bad       = !id_in_range || used_mask[selector.selected_q_id];
  assign timer_freeze = (state != S_ANSWER) || answer_valid;
  assign game_over    = (state == S_OVER);
  assign state_out    = state;

`ifdef TIME_BONUS_EN
  assign score_sum = {1'b0, score} + 9'd1 + 9'(time_left);
`else
  assign score_sum = {1'b0, score} + 9'd1;
`endif

  round_timer #(.TIME_W(TIME_W)) u_timer (
    .clk       (clk_100mhz),
    .reset_n   (reset_n),
    .load      (timer_load),
    .load_val  (timer_val),
    .tick      (game_tick),
    .freeze    (timer_freeze),
    .time_left (time_left),
    .expire    (expire)
  );

  // next-state and per-cycle control decode
  always_comb begin
    state_nxt                = state;
    accept                   = 1'b0;
    reject                   = 1'b0;
    game_start               = 1'b0;
    verdict_ok               = 1'b0;
    verdict_bad              = 1'b0;
    timer_load               = 1'b0;
    timer_val                = '0;
    selector.question_enable = 1'b0;
    case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          game_start = 1'b1;
          timer_load = 1'b1;
          state_nxt  = S_REQUEST;
        end
      end
      S_REQUEST: begin
        selector.question_enable = 1'b1;
        state_nxt                = S_WAIT_Q;
      end
      S_WAIT_Q: begin
        if (selector.question_ready) begin
          if (id_bad && (retry < 4'(MAX_RETRY))) begin
            reject    = 1'b1;
            state_nxt = S_REQUEST;
          end else begin
            accept     = 1'b1;
            timer_load = 1'b1;
            timer_val  = TIME_W'(ROUND_TIME);
            state_nxt  = S_ANSWER;
          end
        end else if (cnt == 4'd15) begin
          state_nxt = S_REQUEST;
        end
      end
      S_ANSWER: begin
        // an answer in the same cycle as the final tick takes priority
        if (answer_valid) begin
          verdict_ok  = (answer_value == cur_ans);
          verdict_bad = (answer_value != cur_ans);
          state_nxt   = S_RESULT;
        end else if (expire) begin
          verdict_bad = 1'b1;
          state_nxt   = S_RESULT;
        end
      end
      S_RESULT: begin
        if (game_tick && (cnt == 4'(RESULT_HOLD - 1))) begin
          if ((lives == 2'd0) || (round_num == 4'(NUM_ROUNDS)))
            state_nxt = S_OVER;
          else
            state_nxt = S_REQUEST;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_100mhz) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // shared counter: watchdog cycles in WAIT_Q, hold ticks in RESULT; restarts on every state change
  always_ff @(posedge clk_100mhz) begin
    if (!reset_n)
      cnt <= '0;
    else if (state_nxt != state)
      cnt <= '0;
    else if ((state == S_WAIT_Q) || ((state == S_RESULT) && game_tick))
      cnt <= cnt + 4'd1;
  end

  // question acceptance: retry count, latched id/answer, used-question mask
  always_ff @(posedge clk_100mhz) begin
    if (!reset_n) begin
      retry     <= '0;
      used_mask <= '0;
      cur_q_id  <= '0;
      cur_ans   <= '0;
    end else begin
      if (game_start || accept) retry <= '0;
      else if (reject)          retry <= retry + 4'd1;
      if (accept) begin
        cur_q_id <= selector.selected_q_id;
        cur_ans  <= selector.correct_ans;
      end
      // a full mask empties one cycle after the accept that filled it
      if (game_start || (used_mask == MASK_FULL))
        used_mask <= '0;
      else if (accept && id_in_range)
        used_mask[selector.selected_q_id] <= 1'b1;
    end
  end

  // score, lives, round count and verdict pulses
  always_ff @(posedge clk_100mhz) begin
    if (!reset_n) begin
      score          <= '0;
      lives          <= 2'(START_LIVES);
      round_num      <= '0;
      result_correct <= 1'b0;
      result_wrong   <= 1'b0;
    end else begin
      result_correct <= verdict_ok;
      result_wrong   <= verdict_bad;
      if (game_start) begin
        score     <= '0;
        lives     <= 2'(START_LIVES);
        round_num <= '0;
      end else if (verdict_ok) begin
        score     <= score_sum[8] ? 8'hFF : score_sum[7:0];
        round_num <= round_num + 4'd1;
      end else if (verdict_bad) begin
        if (lives != 2'd0) lives <= lives - 2'd1;
        round_num <= round_num + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_quiz_round_controller.sv
// Directed bench for quiz_round_controller: cycle vector table plus hand sequences.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// Expected values are hand-computed for ROUND_TIME=10, START_LIVES=3, RESULT_HOLD=2, MAX_RETRY=3.
module tb_quiz_round_controller;
  import quiz_pkg::*;

`ifdef TIME_BONUS_EN
  localparam int S1 = 8;   // 1 + 7 ticks left
  localparam int S2 = 10;  // 8 + 1 + 1 tick left
`else
  localparam int S1 = 1;
  localparam int S2 = 2;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       game_tick, start, answer_valid;
  logic [3:0] answer_value;
  logic [3:0] cur_q_id;
  logic [3:0] time_left;
  logic [7:0] score;
  logic [1:0] lives;
  logic [3:0] round_num;
  logic       result_correct, result_wrong, game_over;
  logic [2:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;

  quiz_round_controller_if sel_if ();

  quiz_round_controller dut (
    .clk_100mhz     (clk),
    .reset_n        (reset_n),
    .game_tick      (game_tick),
    .start          (start),
    .answer_valid   (answer_valid),
    .answer_value   (answer_value),
    .selector       (sel_if),
    .cur_q_id       (cur_q_id),
    .time_left      (time_left),
    .score          (score),
    .lives          (lives),
    .round_num      (round_num),
    .result_correct (result_correct),
    .result_wrong   (result_wrong),
    .game_over      (game_over),
    .state_out      (state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start, tick, av;
    logic [3:0] aval;
    logic       qr;
    logic [3:0] qid, qans;
    logic [2:0] st;
    logic       qen;
    logic [7:0] sc;
    logic [1:0] lv;
    logic [3:0] rn, tl;
    logic       rc, rw;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic s, input logic t, input logic av, input logic [3:0] aval,
                     input logic qr, input logic [3:0] qid, input logic [3:0] qans);
    start = s; game_tick = t; answer_valid = av; answer_value = aval;
    sel_if.question_ready = qr; sel_if.selected_q_id = qid; sel_if.correct_ans = qans;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string nm, input logic [2:0] st, input logic qen,
                            input logic [7:0] sc, input logic [1:0] lv, input logic [3:0] rn,
                            input logic [3:0] tl, input logic rc, input logic rw);
    chk({nm, ".state"},  32'(state_out), 32'(st));
    chk({nm, ".qen"},    32'(sel_if.question_enable), 32'(qen));
    chk({nm, ".score"},  32'(score), 32'(sc));
    chk({nm, ".lives"},  32'(lives), 32'(lv));
    chk({nm, ".round"},  32'(round_num), 32'(rn));
    chk({nm, ".time"},   32'(time_left), 32'(tl));
    chk({nm, ".rc"},     32'(result_correct), 32'(rc));
    chk({nm, ".rw"},     32'(result_wrong), 32'(rw));
    chk({nm, ".over"},   32'(game_over), 32'(st == ST_OVER));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // start, tick, av, aval, qr, qid, qans | st, qen, score, lives, round, time, rc, rw
    vecs[0]  = '{1,0,0,0,  0,0,0,   ST_REQUEST,1,0, 3,0,0, 0,0};
    vecs[1]  = '{0,0,0,0,  0,0,0,   ST_WAIT_Q, 0,0, 3,0,0, 0,0};
    vecs[2]  = '{0,0,0,0,  1,4,15,  ST_ANSWER, 0,0, 3,0,10,0,0};
    vecs[3]  = '{1,1,0,0,  0,0,0,   ST_ANSWER, 0,0, 3,0,9, 0,0};  // start ignored
    vecs[4]  = '{0,1,0,0,  0,0,0,   ST_ANSWER, 0,0, 3,0,8, 0,0};
    vecs[5]  = '{0,1,0,0,  0,0,0,   ST_ANSWER, 0,0, 3,0,7, 0,0};
    vecs[6]  = '{0,0,1,15, 0,0,0,   ST_RESULT, 0,S1,3,1,7, 1,0};
    vecs[7]  = '{0,0,1,0,  0,0,0,   ST_RESULT, 0,S1,3,1,7, 0,0};  // answer outside ANSWER ignored
    vecs[8]  = '{0,1,0,0,  0,0,0,   ST_RESULT, 0,S1,3,1,7, 0,0};
    vecs[9]  = '{0,1,0,0,  0,0,0,   ST_REQUEST,1,S1,3,1,7, 0,0};
    vecs[10] = '{0,0,0,0,  0,0,0,   ST_WAIT_Q, 0,S1,3,1,7, 0,0};
    vecs[11] = '{0,0,0,0,  1,4,0,   ST_REQUEST,1,S1,3,1,7, 0,0};  // repeat id, retry 1
    vecs[12] = '{0,0,0,0,  0,0,0,   ST_WAIT_Q, 0,S1,3,1,7, 0,0};
    vecs[13] = '{0,0,0,0,  1,12,0,  ST_REQUEST,1,S1,3,1,7, 0,0};  // invalid id, retry 2
    vecs[14] = '{0,0,0,0,  0,0,0,   ST_WAIT_Q, 0,S1,3,1,7, 0,0};
    vecs[15] = '{0,0,0,0,  1,4,0,   ST_REQUEST,1,S1,3,1,7, 0,0};  // repeat, retry 3
    vecs[16] = '{0,0,0,0,  0,0,0,   ST_WAIT_Q, 0,S1,3,1,7, 0,0};
    vecs[17] = '{0,0,0,0,  1,4,5,   ST_ANSWER, 0,S1,3,1,10,0,0};  // retries exhausted: accepted
    vecs[18] = '{0,0,1,6,  0,0,0,   ST_RESULT, 0,S1,2,2,10,0,1};
    vecs[19] = '{0,1,0,0,  0,0,0,   ST_RESULT, 0,S1,2,2,10,0,0};
    vecs[20] = '{0,1,0,0,  0,0,0,   ST_REQUEST,1,S1,2,2,10,0,0};
    vecs[21] = '{0,0,0,0,  0,0,0,   ST_WAIT_Q, 0,S1,2,2,10,0,0};
    vecs[22] = '{0,0,0,0,  1,7,2,   ST_ANSWER, 0,S1,2,2,10,0,0};

    // reset held for two cycles
    reset_n = 1'b0;
    cyc(0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0);
    expect_all("reset", ST_IDLE, 0, 0, 3, 0, 0, 0, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      cyc(vecs[i].start, vecs[i].tick, vecs[i].av, vecs[i].aval,
          vecs[i].qr, vecs[i].qid, vecs[i].qans);
      expect_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].qen, vecs[i].sc,
                 vecs[i].lv, vecs[i].rn, vecs[i].tl, vecs[i].rc, vecs[i].rw);
    end
    chk("accepted_id", 32'(cur_q_id), 32'd7);

    // timeout: the tenth tick with no answer is a wrong verdict
    for (int i = 1; i <= 9; i++) begin
      cyc(0,1,0,0,0,0,0);
      expect_all("countdown", ST_ANSWER, 0, S1, 2, 2, 4'(10 - i), 0, 0);
    end
    cyc(0,1,0,0,0,0,0);
    expect_all("timeout", ST_RESULT, 0, S1, 1, 3, 0, 0, 1);
    cyc(0,1,0,0,0,0,0);
    cyc(0,1,0,0,0,0,0);
    expect_all("hold2", ST_REQUEST, 1, S1, 1, 3, 0, 0, 0);

    // correct answer on the same cycle as the final tick
    cyc(0,0,0,0,0,0,0);
    cyc(0,0,0,0,1,1,9);
    expect_all("accept_id1", ST_ANSWER, 0, S1, 1, 3, 10, 0, 0);
    for (int i = 1; i <= 9; i++) cyc(0,1,0,0,0,0,0);
    chk("last_tick_time", 32'(time_left), 32'd1);
    cyc(0,1,1,9,0,0,0);
    expect_all("ans_vs_tick", ST_RESULT, 0, S2, 1, 4, 1, 1, 0);
    cyc(0,0,0,0,0,0,0);
    expect_all("no_late_timeout", ST_RESULT, 0, S2, 1, 4, 1, 0, 0);

    // last life lost -> OVER
    cyc(0,1,0,0,0,0,0);
    cyc(0,1,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0);
    cyc(0,0,0,0,1,2,3);
    cyc(0,0,1,0,0,0,0);
    expect_all("last_life", ST_RESULT, 0, S2, 0, 5, 10, 0, 1);
    cyc(0,1,0,0,0,0,0);
    cyc(0,1,0,0,0,0,0);
    expect_all("over", ST_OVER, 0, S2, 0, 5, 10, 0, 0);
    cyc(0,1,1,3,1,5,5);
    expect_all("over_hold", ST_OVER, 0, S2, 0, 5, 10, 0, 0);
    cyc(1,0,0,0,0,0,0);
    expect_all("restart", ST_REQUEST, 1, 0, 3, 0, 0, 0, 0);

    // watchdog: 16 silent cycles in WAIT_Q re-issue the request
    cyc(0,0,0,0,0,0,0);
    for (int i = 1; i <= 15; i++) begin
      cyc(0,0,0,0,0,0,0);
      chk("wd_wait", 32'(state_out), 32'(ST_WAIT_Q));
    end
    cyc(0,0,0,0,0,0,0);
    expect_all("watchdog", ST_REQUEST, 1, 0, 3, 0, 0, 0, 0);

    // mask cleared on restart, so id 4 is accepted first time
    cyc(0,0,0,0,0,0,0);
    cyc(0,0,0,0,1,4,1);
    expect_all("mask_cleared", ST_ANSWER, 0, 0, 3, 0, 10, 0, 0);
    chk("accepted_id4", 32'(cur_q_id), 32'd4);
    cyc(0,1,0,0,0,0,0);

    // reset in ANSWER returns to IDLE at once; a late ready is ignored
    reset_n = 1'b0;
    cyc(0,0,0,0,0,0,0);
    expect_all("mid_reset", ST_IDLE, 0, 0, 3, 0, 0, 0, 0);
    chk("mid_reset_id", 32'(cur_q_id), 32'd0);
    reset_n = 1'b1;
    cyc(0,0,0,0,1,3,3);
    expect_all("late_ready", ST_IDLE, 0, 0, 3, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
